// File: rtl/txt_pkg.sv
// Shared constants, FSM state type and ASCII-to-screen-code mapping for the 40x24 text page.
package txt_pkg;

  localparam int unsigned COLS  = 40;
  localparam int unsigned ROWS  = 24;
  localparam int unsigned CELLS = COLS * ROWS;

  localparam logic [15:0] TXT_BASE = 16'h0400;
  localparam logic [7:0]  BLANK    = 8'hA0;

  localparam logic [5:0] LAST_COL = 6'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    PUT,
    CLEAR,
    SCROLL_RD,
    SCROLL_WR,
    CLRLINE
  } txt_state_t;

  // Only meaningful for printable input (0x20..0x7F after masking bit 7).
  function automatic logic [7:0] ascii_to_code(input logic [7:0] ascii);
    logic [7:0] c;
    c = ascii & 8'h7F;
    if (c >= 8'h60) return (c - 8'h20) | 8'h80;
    return c | 8'h80;
  endfunction

endpackage

// File: rtl/txt_console_writer_cursor.sv
// Cursor column/row counters with advance, newline, backspace and home, plus linear cell index.
// End-of-page row behaviour follows TXT_SCROLL_EN (hold last row) or wraps to row 0.
module txt_cursor
  import txt_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        adv,
  input  logic        nl,
  input  logic        bs,
  input  logic        home,
  output logic [5:0]  col,
  output logic [4:0]  row,
  output logic [15:0] cell_idx,
  output logic        at_last_col,
  output logic        at_last_row
);

  logic [4:0] next_row;

  always_comb begin
    at_last_col = (col == LAST_COL);
    at_last_row = (row == LAST_ROW);
`ifdef TXT_SCROLL_EN
    next_row = at_last_row ? LAST_ROW : row + 5'd1;
`else
    next_row = at_last_row ? '0 : row + 5'd1;
`endif
    // row*40 as row*32 + row*8, kept in 16 bits
    cell_idx = (16'(row) << 5) + (16'(row) << 3) + 16'(col);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || home) begin
      col <= '0;
      row <= '0;
    end else if (adv) begin
      if (at_last_col) begin
        col <= '0;
        row <= next_row;
      end else begin
        col <= col + 6'd1;
      end
    end else if (nl) begin
      col <= '0;
      row <= next_row;
    end else if (bs && col != '0) begin
      col <= col - 6'd1;
    end
  end

endmodule

// File: rtl/txt_console_writer.sv
// Text console writer: decodes host bytes into text RAM writes, cursor moves, clear and end-of-page.
// Build option TXT_SCROLL_EN: scroll page up at end-of-page instead of wrapping to row 0.
module txt_console_writer
  import txt_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic        mem_we,
  output logic [15:0] mem_adr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  txt_state_t  state;
  logic [7:0]  wdata_q;
  logic [15:0] cnt;
  logic        eop_pend;

  logic [15:0] cell_idx;
  logic        at_last_col, at_last_row;
  logic [7:0]  c;
  logic        accept, is_print, is_nl, is_bs, is_ff, eop_now, clear_done;
  txt_state_t  eop_state;
  logic [15:0] eop_adr;
  logic        eop_we;

  always_comb begin
    c          = ch_data & 8'h7F;
    accept     = (state == IDLE) && ch_valid && ch_ready;
    is_print   = (c >= 8'h20);
    is_nl      = (c == 8'h0D);
    is_bs      = (c == 8'h08);
    is_ff      = (c == 8'h0C);
    eop_now    = at_last_row && (is_nl || (is_print && at_last_col));
    clear_done = (state == CLEAR) && (cnt == 16'(CELLS - 1));
`ifdef TXT_SCROLL_EN
    eop_state  = SCROLL_RD;
    eop_adr    = TXT_BASE + 16'(COLS);
    eop_we     = 1'b0;
`else
    eop_state  = CLRLINE;
    eop_adr    = TXT_BASE;
    eop_we     = 1'b1;
`endif
  end

  txt_cursor u_cursor (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .adv         (accept && is_print),
    .nl          (accept && is_nl),
    .bs          (accept && is_bs),
    .home        (clear_done),
    .col         (cursor_col),
    .row         (cursor_row),
    .cell_idx    (cell_idx),
    .at_last_col (at_last_col),
    .at_last_row (at_last_row)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      ch_ready <= 1'b0;
      mem_we   <= 1'b0;
      mem_adr  <= TXT_BASE;
      wdata_q  <= BLANK;
      busy     <= 1'b0;
      cnt      <= '0;
      eop_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ch_ready <= 1'b1;
          mem_we   <= 1'b0;
          if (accept) begin
            if (is_print) begin
              state    <= PUT;
              ch_ready <= 1'b0;
              mem_we   <= 1'b1;
              mem_adr  <= TXT_BASE + cell_idx;
              wdata_q  <= ascii_to_code(ch_data);
              eop_pend <= eop_now;
            end else if (is_bs && cursor_col != '0) begin
              state    <= PUT;
              ch_ready <= 1'b0;
              mem_we   <= 1'b1;
              mem_adr  <= TXT_BASE + cell_idx - 16'd1;
              wdata_q  <= BLANK;
              eop_pend <= 1'b0;
            end else if (is_nl && at_last_row) begin
              state    <= eop_state;
              ch_ready <= 1'b0;
              busy     <= 1'b1;
              mem_we   <= eop_we;
              mem_adr  <= eop_adr;
              wdata_q  <= BLANK;
              cnt      <= '0;
            end else if (is_ff) begin
              state    <= CLEAR;
              ch_ready <= 1'b0;
              busy     <= 1'b1;
              mem_we   <= 1'b1;
              mem_adr  <= TXT_BASE;
              wdata_q  <= BLANK;
              cnt      <= '0;
            end
          end
        end
        PUT: begin
          // A character written into the last cell still owes the end-of-page sequence.
          if (eop_pend) begin
            state    <= eop_state;
            busy     <= 1'b1;
            mem_we   <= eop_we;
            mem_adr  <= eop_adr;
            wdata_q  <= BLANK;
            cnt      <= '0;
            eop_pend <= 1'b0;
          end else begin
            state    <= IDLE;
            ch_ready <= 1'b1;
            mem_we   <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt == 16'(CELLS - 1)) begin
            state    <= IDLE;
            ch_ready <= 1'b1;
            busy     <= 1'b0;
            mem_we   <= 1'b0;
          end else begin
            cnt     <= cnt + 16'd1;
            mem_adr <= mem_adr + 16'd1;
          end
        end
`ifdef TXT_SCROLL_EN
        SCROLL_RD: begin
          state   <= SCROLL_WR;
          mem_we  <= 1'b1;
          mem_adr <= TXT_BASE + cnt;
        end
        SCROLL_WR: begin
          if (cnt == 16'(CELLS - COLS - 1)) begin
            state   <= CLRLINE;
            mem_we  <= 1'b1;
            mem_adr <= TXT_BASE + 16'(CELLS - COLS);
            wdata_q <= BLANK;
            cnt     <= '0;
          end else begin
            state   <= SCROLL_RD;
            mem_we  <= 1'b0;
            mem_adr <= TXT_BASE + cnt + 16'(COLS + 1);
            cnt     <= cnt + 16'd1;
          end
        end
`endif
        CLRLINE: begin
          if (cnt == 16'(COLS - 1)) begin
            state    <= IDLE;
            ch_ready <= 1'b1;
            busy     <= 1'b0;
            mem_we   <= 1'b0;
          end else begin
            cnt     <= cnt + 16'd1;
            mem_adr <= mem_adr + 16'd1;
          end
        end
        default: begin
          state    <= IDLE;
          ch_ready <= 1'b0;
          busy     <= 1'b0;
          mem_we   <= 1'b0;
        end
      endcase
    end
  end

`ifdef TXT_SCROLL_EN
  // Scroll copy forwards read data straight into the write issued in SCROLL_WR.
  assign mem_wdata = (state == SCROLL_WR) ? mem_rdata : wdata_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^mem_rdata;
  assign mem_wdata    = wdata_q;
`endif

endmodule
